// File: rtl/dpram_pkg.sv
// rtl/dpram_pkg.sv - shared burst FSM state type and burst address helper
package dpram_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2
  } burst_state_e;

  // Wrap keeps the upper bits of start and cycles the low lw bits within the window.
  function automatic logic [31:0] burst_addr(input logic [31:0] start,
                                             input logic [31:0] beat,
                                             input logic        wrap,
                                             input int unsigned aw,
                                             input int unsigned lw);
    logic [31:0] full_mask;
    logic [31:0] low_mask;
    logic [31:0] sum;
    full_mask = (32'd1 << aw) - 32'd1;
    low_mask  = (32'd1 << lw) - 32'd1;
    sum       = start + beat;
    if (wrap) begin
      return ((start & ~low_mask) | (sum & low_mask)) & full_mask;
    end
    return sum & full_mask;
  endfunction

endpackage

// File: rtl/dpram_burst_agen.sv
// rtl/dpram_burst_agen.sv - per-port burst FSM, beat counter and address generator
module dpram_burst_agen
  import dpram_pkg::*;
#(
  parameter int ADDR_WIDTH = 6,
  parameter int LEN_W      = 3
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic                  cmd_we_i,
  input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
  input  logic [LEN_W-1:0]      cmd_len_i,
  input  logic                  cmd_wrap_i,
  input  logic                  wvalid_i,
  output logic                  wready_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic                  mem_we_o,
  output logic                  mem_re_o,
  output logic                  rvalid_o,
  output logic                  rlast_o,
  output logic                  done_o
);

  burst_state_e          state_q, state_d;
  logic [LEN_W-1:0]      beat_q, beat_d;
  logic [LEN_W-1:0]      len_q, len_d;
  logic [ADDR_WIDTH-1:0] start_q, start_d;
  logic                  wrap_q, wrap_d;
  logic                  done_q, done_d;
  logic                  rvalid_q, rlast_q;
  logic                  last;

  assign last       = (beat_q == len_q);
  assign mem_addr_o = ADDR_WIDTH'(burst_addr(32'(start_q), 32'(beat_q), wrap_q,
                                             ADDR_WIDTH, LEN_W));

  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    len_d       = len_q;
    start_d     = start_q;
    wrap_d      = wrap_q;
    done_d      = 1'b0;
    cmd_ready_o = 1'b0;
    wready_o    = 1'b0;
    mem_we_o    = 1'b0;
    mem_re_o    = 1'b0;
    unique case (state_q)
      IDLE: begin
        // Holding ready low during the done cycle makes the cycle after done the earliest accept.
        cmd_ready_o = ~done_q;
        if (cmd_valid_i && !done_q) begin
          beat_d  = '0;
          len_d   = cmd_len_i;
          start_d = cmd_addr_i;
          wrap_d  = cmd_wrap_i;
          state_d = cmd_we_i ? WRITE : READ;
        end
      end
      WRITE: begin
        wready_o = 1'b1;
        if (wvalid_i) begin
          mem_we_o = 1'b1;
          if (last) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      READ: begin
        mem_re_o = 1'b1;
        if (last) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          beat_d = beat_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      beat_q   <= '0;
      len_q    <= '0;
      start_q  <= '0;
      wrap_q   <= 1'b0;
      done_q   <= 1'b0;
      rvalid_q <= 1'b0;
      rlast_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      beat_q   <= beat_d;
      len_q    <= len_d;
      start_q  <= start_d;
      wrap_q   <= wrap_d;
      done_q   <= done_d;
      rvalid_q <= mem_re_o;
      rlast_q  <= mem_re_o & last;
    end
  end

  assign rvalid_o = rvalid_q;
  assign rlast_o  = rlast_q;
  assign done_o   = done_q;

endmodule

// File: rtl/dpram_burst_engine.sv
// rtl/dpram_burst_engine.sv - dual-port RAM with per-port burst engines; optional DPRAM_COLLISION_FLAG_EN
module dpram_burst_engine
  import dpram_pkg::*;
#(
  parameter int  DATA_WIDTH    = 8,
  parameter int  ADDR_WIDTH    = 6,
  parameter int  MAX_BURST_LEN = 8,
  localparam int LEN_W         = $clog2(MAX_BURST_LEN)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid_a,
  output logic                  cmd_ready_a,
  input  logic                  cmd_we_a,
  input  logic [ADDR_WIDTH-1:0] cmd_addr_a,
  input  logic [LEN_W-1:0]      cmd_len_a,
  input  logic                  cmd_wrap_a,
  input  logic                  wvalid_a,
  output logic                  wready_a,
  input  logic [DATA_WIDTH-1:0] wdata_a,
  output logic                  rvalid_a,
  output logic [DATA_WIDTH-1:0] rdata_a,
  output logic                  rlast_a,
  output logic                  done_a,
  input  logic                  cmd_valid_b,
  output logic                  cmd_ready_b,
  input  logic                  cmd_we_b,
  input  logic [ADDR_WIDTH-1:0] cmd_addr_b,
  input  logic [LEN_W-1:0]      cmd_len_b,
  input  logic                  cmd_wrap_b,
  input  logic                  wvalid_b,
  output logic                  wready_b,
  input  logic [DATA_WIDTH-1:0] wdata_b,
  output logic                  rvalid_b,
  output logic [DATA_WIDTH-1:0] rdata_b,
  output logic                  rlast_b,
  output logic                  done_b
`ifdef DPRAM_COLLISION_FLAG_EN
  ,
  output logic                  coll_ww,
  output logic                  coll_rw
`endif
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] addr_a, addr_b;
  logic                  we_a, we_b, re_a, re_b;
  logic [DATA_WIDTH-1:0] rdata_a_q, rdata_b_q;
  logic                  same_addr;

  dpram_burst_agen #(.ADDR_WIDTH(ADDR_WIDTH), .LEN_W(LEN_W)) u_agen_a (
    .clk_i(clk), .rst_i(rst),
    .cmd_valid_i(cmd_valid_a), .cmd_ready_o(cmd_ready_a), .cmd_we_i(cmd_we_a),
    .cmd_addr_i(cmd_addr_a), .cmd_len_i(cmd_len_a), .cmd_wrap_i(cmd_wrap_a),
    .wvalid_i(wvalid_a), .wready_o(wready_a),
    .mem_addr_o(addr_a), .mem_we_o(we_a), .mem_re_o(re_a),
    .rvalid_o(rvalid_a), .rlast_o(rlast_a), .done_o(done_a)
  );

  dpram_burst_agen #(.ADDR_WIDTH(ADDR_WIDTH), .LEN_W(LEN_W)) u_agen_b (
    .clk_i(clk), .rst_i(rst),
    .cmd_valid_i(cmd_valid_b), .cmd_ready_o(cmd_ready_b), .cmd_we_i(cmd_we_b),
    .cmd_addr_i(cmd_addr_b), .cmd_len_i(cmd_len_b), .cmd_wrap_i(cmd_wrap_b),
    .wvalid_i(wvalid_b), .wready_o(wready_b),
    .mem_addr_o(addr_b), .mem_we_o(we_b), .mem_re_o(re_b),
    .rvalid_o(rvalid_b), .rlast_o(rlast_b), .done_o(done_b)
  );

  assign same_addr = (addr_a == addr_b);

  // Port A is applied last so it wins a same-address write/write.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (we_b) mem[addr_b] <= wdata_b;
      if (we_a) mem[addr_a] <= wdata_a;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_a_q <= '0;
      rdata_b_q <= '0;
    end else begin
      if (re_a) rdata_a_q <= mem[addr_a];
      if (re_b) rdata_b_q <= mem[addr_b];
    end
  end

  assign rdata_a = rdata_a_q;
  assign rdata_b = rdata_b_q;

`ifdef DPRAM_COLLISION_FLAG_EN
  logic coll_ww_q, coll_rw_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      coll_ww_q <= 1'b0;
      coll_rw_q <= 1'b0;
    end else begin
      coll_ww_q <= we_a & we_b & same_addr;
      coll_rw_q <= ((we_a & re_b) | (re_a & we_b)) & same_addr;
    end
  end

  assign coll_ww = coll_ww_q;
  assign coll_rw = coll_rw_q;
`else
  logic unused_same_addr;
  assign unused_same_addr = same_addr;
`endif

endmodule

// File: tb/tb_dpram_burst_engine.sv
// tb/tb_dpram_burst_engine.sv - scoreboard bench for dpram_burst_engine
module tb_dpram_burst_engine;

  typedef struct {
    logic [7:0] d;
    logic       l;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid [2];
  logic       cmd_ready [2];
  logic       cmd_we    [2];
  logic [5:0] cmd_addr  [2];
  logic [2:0] cmd_len   [2];
  logic       cmd_wrap  [2];
  logic       wvalid    [2];
  logic       wready    [2];
  logic [7:0] wdata     [2];
  logic       rvalid    [2];
  logic [7:0] rdata     [2];
  logic       rlast     [2];
  logic       done      [2];

  logic [7:0] model [64];
  exp_t       sb [2][$];
  int         n_cmp = 0;
  int         n_bad = 0;

`ifdef DPRAM_COLLISION_FLAG_EN
  logic coll_ww, coll_rw;
  int   ww_cnt = 0;
  int   rw_cnt = 0;
  always @(negedge clk) begin
    if (coll_ww) ww_cnt++;
    if (coll_rw) rw_cnt++;
  end
`endif

  dpram_burst_engine dut (
    .clk(clk), .rst(rst),
    .cmd_valid_a(cmd_valid[0]), .cmd_ready_a(cmd_ready[0]), .cmd_we_a(cmd_we[0]),
    .cmd_addr_a(cmd_addr[0]), .cmd_len_a(cmd_len[0]), .cmd_wrap_a(cmd_wrap[0]),
    .wvalid_a(wvalid[0]), .wready_a(wready[0]), .wdata_a(wdata[0]),
    .rvalid_a(rvalid[0]), .rdata_a(rdata[0]), .rlast_a(rlast[0]), .done_a(done[0]),
    .cmd_valid_b(cmd_valid[1]), .cmd_ready_b(cmd_ready[1]), .cmd_we_b(cmd_we[1]),
    .cmd_addr_b(cmd_addr[1]), .cmd_len_b(cmd_len[1]), .cmd_wrap_b(cmd_wrap[1]),
    .wvalid_b(wvalid[1]), .wready_b(wready[1]), .wdata_b(wdata[1]),
    .rvalid_b(rvalid[1]), .rdata_b(rdata[1]), .rlast_b(rlast[1]), .done_b(done[1])
`ifdef DPRAM_COLLISION_FLAG_EN
    , .coll_ww(coll_ww), .coll_rw(coll_rw)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Read monitor: every rvalid beat is matched against the queued expectation.
  always @(negedge clk) begin
    for (int p = 0; p < 2; p++) begin
      if (rvalid[p] === 1'b1) begin
        if (sb[p].size() == 0) begin
          chk($sformatf("unexpected_rvalid_%0d", p), 32'(rdata[p]), 32'hFFFF_FFFF);
        end else begin
          exp_t e;
          e = sb[p].pop_front();
          chk($sformatf("rdata_%0d", p), 32'(rdata[p]), 32'(e.d));
          chk($sformatf("rlast_%0d", p), 32'(rlast[p]), 32'(e.l));
          chk($sformatf("done_with_rlast_%0d", p), 32'(done[p]), 32'(e.l));
        end
      end
    end
  end

  task automatic send_cmd(input int p, input logic we, input logic [5:0] addr,
                          input logic [2:0] len, input logic wrap);
    int n;
    cmd_valid[p] = 1'b1;
    cmd_we[p]    = we;
    cmd_addr[p]  = addr;
    cmd_len[p]   = len;
    cmd_wrap[p]  = wrap;
    n = 0;
    @(negedge clk);
    while (cmd_ready[p] !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk($sformatf("cmd_accept_timeout_%0d", p), 32'(n), 32'd0);
    @(posedge clk);
    #1;
    cmd_valid[p] = 1'b0;
  endtask

  task automatic wait_done(input int p);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (done[p] !== 1'b1 && n < 40);
    chk($sformatf("done_seen_%0d", p), 32'(done[p]), 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic write_burst(input int p, input logic [5:0] addr, input logic [2:0] len,
                             input logic [7:0] d0, input logic [15:0] pat);
    int   beats;
    int   i;
    logic bad_hs;
    logic [5:0] a;
    send_cmd(p, 1'b1, addr, len, 1'b0);
    beats  = 0;
    i      = 0;
    bad_hs = 1'b0;
    while (beats <= int'(len) && i < 40) begin
      wvalid[p] = pat[i % 16];
      wdata[p]  = d0 + 8'(beats);
      @(negedge clk);
      if (cmd_ready[p] !== 1'b0 || wready[p] !== 1'b1 || done[p] !== 1'b0) bad_hs = 1'b1;
      if (wvalid[p] && wready[p]) begin
        a = addr + 6'(beats);
        model[a] = wdata[p];
        beats++;
      end
      @(posedge clk);
      #1;
      i++;
    end
    wvalid[p] = 1'b0;
    chk($sformatf("write_beats_%0d", p), 32'(beats), 32'(len) + 32'd1);
    chk($sformatf("write_handshake_%0d", p), 32'(bad_hs), 32'd0);
    @(negedge clk);
    chk($sformatf("write_done_%0d", p), 32'(done[p]), 32'd1);
    chk($sformatf("ready_low_in_done_%0d", p), 32'(cmd_ready[p]), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic read_burst(input int p, input logic [5:0] addr, input logic [2:0] len,
                            input logic wrap);
    logic [5:0] a;
    exp_t e;
    for (int b = 0; b <= int'(len); b++) begin
      a   = wrap ? {addr[5:3], 3'(addr[2:0] + 3'(b))} : 6'(addr + 6'(b));
      e.d = model[a];
      e.l = (b == int'(len));
      sb[p].push_back(e);
    end
    send_cmd(p, 1'b0, addr, len, wrap);
    wait_done(p);
  endtask

  // Both ports take a one-beat command in the same cycle; writes present data immediately.
  task automatic both_single(input logic we_a, input logic [5:0] a_a, input logic [7:0] d_a,
                             input logic we_b, input logic [5:0] a_b, input logic [7:0] d_b);
    cmd_we[0] = we_a; cmd_addr[0] = a_a; cmd_len[0] = 3'd0; cmd_wrap[0] = 1'b0;
    cmd_we[1] = we_b; cmd_addr[1] = a_b; cmd_len[1] = 3'd0; cmd_wrap[1] = 1'b0;
    cmd_valid[0] = 1'b1;
    cmd_valid[1] = 1'b1;
    @(negedge clk);
    chk("both_ready", {30'd0, cmd_ready[0], cmd_ready[1]}, 32'd3);
    @(posedge clk);
    #1;
    cmd_valid[0] = 1'b0;
    cmd_valid[1] = 1'b0;
    wvalid[0] = we_a; wdata[0] = d_a;
    wvalid[1] = we_b; wdata[1] = d_b;
    @(posedge clk);
    #1;
    wvalid[0] = 1'b0;
    wvalid[1] = 1'b0;
    @(negedge clk);
    chk("both_done", {30'd0, done[0], done[1]}, 32'd3);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic no_done;
    for (int p = 0; p < 2; p++) begin
      cmd_valid[p] = 1'b0; cmd_we[p] = 1'b0; cmd_addr[p] = '0; cmd_len[p] = '0;
      cmd_wrap[p]  = 1'b0; wvalid[p] = 1'b0; wdata[p] = '0;
    end
    for (int i = 0; i < 64; i++) model[i] = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    for (int p = 0; p < 2; p++) begin
      chk($sformatf("rst_cmd_ready_%0d", p), 32'(cmd_ready[p]), 32'd1);
      chk($sformatf("rst_outputs_%0d", p),
          {20'd0, wready[p], rvalid[p], rdata[p], rlast[p], done[p]}, 32'd0);
    end
    @(posedge clk);
    #1;

    // Basic write A then read B
    write_burst(0, 6'h10, 3'd3, 8'hA0, 16'hFFFF);
    read_burst(1, 6'h10, 3'd3, 1'b0);

    // Fill for wrap and top-of-memory tests
    write_burst(0, 6'h08, 3'd7, 8'h80, 16'hFFFF);
    write_burst(1, 6'h38, 3'd7, 8'hC0, 16'hFFFF);
    write_burst(0, 6'h00, 3'd7, 8'h50, 16'hFFFF);
    read_burst(0, 6'h0E, 3'd7, 1'b1);
    read_burst(1, 6'h3E, 3'd3, 1'b0);

    // Stalled write: wvalid 1,0,0,1,1,1
    write_burst(1, 6'h18, 3'd3, 8'h60, 16'h0039);
    read_burst(0, 6'h18, 3'd3, 1'b0);

    // Write/write collision: port A wins
    both_single(1'b1, 6'h20, 8'h11, 1'b1, 6'h20, 8'h22);
    model[6'h20] = 8'h11;
    read_burst(0, 6'h20, 3'd0, 1'b0);
    read_burst(1, 6'h20, 3'd0, 1'b0);
`ifdef DPRAM_COLLISION_FLAG_EN
    chk("coll_ww_pulses", 32'(ww_cnt), 32'd1);
`endif

    // Read/write collision: read-first
    write_burst(0, 6'h05, 3'd0, 8'h33, 16'hFFFF);
    begin
      exp_t e;
      e.d = 8'h33;
      e.l = 1'b1;
      sb[0].push_back(e);
    end
    both_single(1'b0, 6'h05, 8'h00, 1'b1, 6'h05, 8'h44);
    model[6'h05] = 8'h44;
    read_burst(0, 6'h05, 3'd0, 1'b0);
`ifdef DPRAM_COLLISION_FLAG_EN
    chk("coll_rw_pulses", 32'(rw_cnt), 32'd1);
`endif

    // Reset in the middle of a write burst
    write_burst(1, 6'h28, 3'd7, 8'hE0, 16'hFFFF);
    send_cmd(0, 1'b1, 6'h28, 3'd7, 1'b0);
    wvalid[0] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wdata[0] = 8'h90 + 8'(k);
      model[6'h28 + 6'(k)] = wdata[0];
      @(posedge clk);
      #1;
    end
    wdata[0] = 8'h93;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    wvalid[0] = 1'b0;
    @(negedge clk);
    for (int p = 0; p < 2; p++) begin
      chk($sformatf("midrst_cmd_ready_%0d", p), 32'(cmd_ready[p]), 32'd1);
      chk($sformatf("midrst_outputs_%0d", p),
          {20'd0, wready[p], rvalid[p], rdata[p], rlast[p], done[p]}, 32'd0);
    end
    no_done = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (done[0] !== 1'b0 || done[1] !== 1'b0) no_done = 1'b0;
      @(negedge clk);
    end
    chk("midrst_no_done", 32'(no_done), 32'd1);
    @(posedge clk);
    #1;
    read_burst(0, 6'h28, 3'd7, 1'b0);

    repeat (3) @(posedge clk);
    chk("sb_empty_a", 32'(sb[0].size()), 32'd0);
    chk("sb_empty_b", 32'(sb[1].size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
